// File: rtl/alu_seq_param.sv
// -----------------------------------------------------------------------------
// alu_seq_param
//   Parametrised multi-cycle integer ALU with valid/ready handshakes on both
//   the command and the result side. ADD/SUB/AND/OR/XOR/SHL/SHR complete in
//   two cycles. MUL (optional, MUL_EN) is an iterative shift-add multiplier
//   that takes one step per cycle and completes in WIDTH+2 cycles. Results
//   and flags are held in registers from completion until the next completion.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 4)
//   MUL_EN     1: MUL supported, 0: MUL reported as an illegal opcode
//
// Ports
//   clk        clock, all logic on the rising edge
//   reset      synchronous, active-high
//   in_valid   command present on op_code/num_1/num_2
//   in_ready   block can accept a command (high only while idle)
//   op_code    operation select (01 ADD .. 08 MUL, anything else illegal)
//   num_1      operand A
//   num_2      operand B / shift amount
//   result     result (low half for MUL)
//   result_hi  high half of the MUL product, 0 for every other op
//   flag_z     result (and result_hi) all zero, 0 on an illegal opcode
//   flag_c     ADD carry-out / SUB borrow
//   flag_v     ADD/SUB signed overflow
//   flag_err   illegal opcode
//   out_valid  result/flags valid, held until out_ready
//   out_ready  consumer accepts the result
// -----------------------------------------------------------------------------
module alu_seq_param #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       op_code,
    input  logic [WIDTH-1:0] num_1,
    input  logic [WIDTH-1:0] num_2,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_err,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_AND = 8'h03;
    localparam logic [7:0] OP_OR  = 8'h04;
    localparam logic [7:0] OP_XOR = 8'h05;
    localparam logic [7:0] OP_SHL = 8'h06;
    localparam logic [7:0] OP_SHR = 8'h07;
    localparam logic [7:0] OP_MUL = 8'h08;

    localparam bit MUL_OK = (MUL_EN != 0);

    // Step counter only has to reach WIDTH-1.
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [7:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic               flag_z_q;
    logic               flag_c_q;
    logic               flag_v_q;
    logic               flag_err_q;
    logic               out_valid_q;

    // Single-cycle ALU results computed from the captured command.
    logic [WIDTH:0]     sum_d;
    logic [WIDTH-1:0]   diff_d;
    logic [WIDTH-1:0]   alu_res_d;
    logic               alu_c_d;
    logic               alu_v_d;
    logic               alu_err_d;
    logic               alu_z_d;

    // One shift-add multiplier step.
    logic [WIDTH:0]     mul_sum_d;
    logic [2*WIDTH-1:0] prod_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        sum_d     = {1'b0, a_q} + {1'b0, b_q};
        diff_d    = a_q - b_q;
        alu_res_d = '0;
        alu_c_d   = 1'b0;
        alu_v_d   = 1'b0;
        alu_err_d = 1'b0;

        case (op_q)
            OP_ADD: begin
                alu_res_d = sum_d[WIDTH-1:0];
                alu_c_d   = sum_d[WIDTH];
                // Same-sign operands producing an opposite-sign result.
                alu_v_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                            (sum_d[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_d = diff_d;
                alu_c_d   = (a_q < b_q);
                // Different-sign operands with the result sign flipped from A.
                alu_v_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                            (diff_d[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: alu_res_d = a_q & b_q;
            OP_OR:  alu_res_d = a_q | b_q;
            OP_XOR: alu_res_d = a_q ^ b_q;
            // Shifts by the full num_2 value; amounts >= WIDTH give zero.
            OP_SHL: alu_res_d = a_q << b_q;
            OP_SHR: alu_res_d = a_q >> b_q;
            // Reaches the ALU load only when the multiplier is disabled.
            OP_MUL: alu_err_d = !MUL_OK;
            default: alu_err_d = 1'b1;
        endcase

        alu_z_d = (alu_res_d == '0) && !alu_err_d;
    end

    // Right-shifting product register: the upper half accumulates the
    // multiplicand whenever the current multiplier LSB (prod_q[0]) is set.
    always_comb begin
        mul_sum_d = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    (prod_q[0] ? {1'b0, a_q} : {(WIDTH + 1){1'b0}});
        prod_d    = {mul_sum_d, prod_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            flag_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q    <= op_code;
                        a_q     <= num_1;
                        b_q     <= num_2;
                        state_q <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (MUL_OK && (op_q == OP_MUL)) begin
                        prod_q  <= {{WIDTH{1'b0}}, b_q};
                        cnt_q   <= '0;
                        state_q <= S_MUL;
                    end else begin
                        result_q    <= alu_res_d;
                        result_hi_q <= '0;
                        flag_z_q    <= alu_z_d;
                        flag_c_q    <= alu_c_d;
                        flag_v_q    <= alu_v_d;
                        flag_err_q  <= alu_err_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end

                S_MUL: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        result_q    <= prod_d[WIDTH-1:0];
                        result_hi_q <= prod_d[2*WIDTH-1:WIDTH];
                        flag_z_q    <= (prod_d == '0);
                        flag_c_q    <= 1'b0;
                        flag_v_q    <= 1'b0;
                        flag_err_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;
    assign flag_err  = flag_err_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_param
//   Self-checking bench for alu_seq_param (WIDTH=8). A MUL-enabled instance
//   runs directed and randomized commands against an arithmetic reference
//   model; a MUL-disabled instance covers MUL reported as illegal.
// -----------------------------------------------------------------------------
module tb_alu_seq_param;

    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clk;
    logic         reset;
    logic [7:0]   op_code;
    logic [W-1:0] num_1;
    logic [W-1:0] num_2;

    // MUL-enabled instance
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] result, result_hi;
    logic         flag_z, flag_c, flag_v, flag_err;

    // MUL-disabled instance
    logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [W-1:0] result_b, result_hi_b;
    logic         flag_z_b, flag_c_b, flag_v_b, flag_err_b;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq_param #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_code(op_code), .num_1(num_1), .num_2(num_2),
        .result(result), .result_hi(result_hi),
        .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .flag_err(flag_err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    alu_seq_param #(.WIDTH(W), .MUL_EN(0)) dut_nomul (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .op_code(op_code), .num_1(num_1), .num_2(num_2),
        .result(result_b), .result_hi(result_hi_b),
        .flag_z(flag_z_b), .flag_c(flag_c_b), .flag_v(flag_v_b), .flag_err(flag_err_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int res;
        int hi;
        bit z;
        bit c;
        bit v;
        bit err;
    } exp_t;

    // Reference model: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int op, input int a, input int b, input bit mul_en);
        exp_t e;
        int   sa, sb, s, ss, p;
        e = '{res: 0, hi: 0, z: 1'b0, c: 1'b0, v: 1'b0, err: 1'b0};
        sa = (a >= M / 2) ? a - M : a;
        sb = (b >= M / 2) ? b - M : b;
        case (op)
            1: begin
                s = a + b;   e.res = s % M;       e.c = (s >= M);
                ss = sa + sb; e.v = (ss >= M / 2) || (ss < -(M / 2));
            end
            2: begin
                s = a - b;   e.res = (s + M) % M; e.c = (a < b);
                ss = sa - sb; e.v = (ss >= M / 2) || (ss < -(M / 2));
            end
            3: e.res = a & b;
            4: e.res = a | b;
            5: e.res = a ^ b;
            6: e.res = (b >= W) ? 0 : (a * (1 << b)) % M;
            7: e.res = (b >= W) ? 0 : a / (1 << b);
            8: begin
                if (mul_en) begin
                    p = a * b; e.res = p % M; e.hi = p / M;
                end else begin
                    e.err = 1'b1;
                end
            end
            default: e.err = 1'b1;
        endcase
        e.z = !e.err && (e.res == 0) && (e.hi == 0);
        return e;
    endfunction

    function automatic logic [19:0] pack_exp(input exp_t e);
        return {8'(e.hi), 8'(e.res), e.z, e.c, e.v, e.err};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One command on the MUL-enabled instance, with `hold` cycles of
    // backpressure in DONE while a junk command is offered.
    task automatic do_op(input int op, input int a, input int b, input int hold, input string tag);
        exp_t e;
        int   cyc;
        e = model(op, a, b, 1'b1);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op_code  = 8'(op);
        num_1    = W'(a);
        num_2    = W'(b);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), (op == 8) ? 32'(W + 2) : 32'd2);
        check({tag, "_out"}, 32'({result_hi, result, flag_z, flag_c, flag_v, flag_err}),
              32'(pack_exp(e)));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op_code  = 8'h04;
            num_1    = W'($urandom);
            num_2    = W'($urandom);
            @(negedge clk);
            check({tag, "_hold_ready"}, 32'({in_ready, out_valid}), 32'b01);
            check({tag, "_hold_out"}, 32'({result_hi, result, flag_z, flag_c, flag_v, flag_err}),
                  32'(pack_exp(e)));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_release"}, 32'({in_ready, out_valid}), 32'b10);
        check({tag, "_persist"}, 32'({result_hi, result, flag_z, flag_c, flag_v, flag_err}),
              32'(pack_exp(e)));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   op, a, b, cyc;

        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_valid_b  = 1'b0;
        out_ready_b = 1'b0;
        op_code     = '0;
        num_1       = '0;
        num_2       = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_out", 32'({result_hi, result, flag_z, flag_c, flag_v, flag_err, out_valid}), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        do_op(8'h01, 8'hFF, 8'h01, 0,  "add_ff_01");
        do_op(8'h01, 8'h7F, 8'h01, 0,  "add_7f_01");
        do_op(8'h02, 8'h03, 8'h05, 0,  "sub_03_05");
        do_op(8'h02, 8'h80, 8'h01, 0,  "sub_ovf");
        do_op(8'h06, 8'h81, 8'h01, 0,  "shl_81_1");
        do_op(8'h07, 8'hA5, 8'h09, 0,  "shr_by_9");
        do_op(8'h08, 8'hFF, 8'hFF, 0,  "mul_ff_ff");
        do_op(8'h08, 8'h37, 8'h00, 0,  "mul_x_0");
        do_op(8'h05, 8'h5A, 8'hC3, 10, "xor_backpressure");
        do_op(8'h2A, 8'h12, 8'h34, 0,  "illegal_2a");

        // Reset in the middle of a multiply: nothing may complete afterwards.
        do_op(8'h01, 8'h12, 8'h34, 0, "add_before_reset");
        @(negedge clk);
        in_valid = 1'b1;
        op_code  = 8'h08;
        num_1    = 8'hFF;
        num_2    = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("midmul_reset_out", 32'({result_hi, result, flag_z, flag_c, flag_v, flag_err, out_valid}), 32'd0);
        check("midmul_reset_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("midmul_no_stale", 32'({out_valid, in_ready}), 32'b01);
        end

        // MUL with the multiplier disabled completes as an illegal opcode.
        @(negedge clk);
        in_valid_b = 1'b1;
        op_code    = 8'h08;
        num_1      = 8'h12;
        num_2      = 8'h34;
        @(negedge clk);
        in_valid_b = 1'b0;
        cyc = 1;
        while (!out_valid_b && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("nomul_latency", 32'(cyc), 32'd2);
        e = model(8, 8'h12, 8'h34, 1'b0);
        check("nomul_out", 32'({result_hi_b, result_b, flag_z_b, flag_c_b, flag_v_b, flag_err_b}),
              32'(pack_exp(e)));
        out_ready_b = 1'b1;
        @(negedge clk);
        out_ready_b = 1'b0;
        check("nomul_release", 32'({in_ready_b, out_valid_b}), 32'b10);

        // Randomized commands
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 8);
            if (op == 0) op = $urandom_range(9, 255);
            a = $urandom_range(0, M - 1);
            b = $urandom_range(0, M - 1);
            if ((op == 6 || op == 7) && ($urandom_range(0, 3) != 0)) b = $urandom_range(0, 12);
            if ($urandom_range(0, 7) == 0) b = 0;
            do_op(op, a, b, $urandom_range(0, 3), $sformatf("rand%0d_op%0h", n, op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
